// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between eight requesters and the arbiter
//   req       : request vector, bit i = requester i
//   gnt       : one-hot grant
//   gnt_idx   : binary index of current or most recent owner
//   gnt_valid : high when gnt is nonzero
//   preempt   : one-cycle pulse when an owner loses its grant by timeout
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, preempt
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, preempt
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold timeout and preemption
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_arbiter8_if.slave (req in; gnt, gnt_idx, gnt_valid, preempt out, all registered)
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;
  logic       r_preempt;
  logic [7:0] r_hold;
  logic [2:0] r_last_owner;

  logic [2:0] w_win_idx;
  logic       w_win_found;
  logic       w_owner_req;
  logic       w_others_req;

  // Search starts just after the last owner so it ends up with lowest priority.
  always_comb begin
    logic [2:0] v_cand;
    w_win_idx   = 3'd0;
    w_win_found = 1'b0;
    v_cand      = 3'd0;
    for (int k = 1; k < 9; k++) begin
      v_cand = r_last_owner + k[2:0];
      if (!w_win_found && bus.req[v_cand]) begin
        w_win_idx   = v_cand;
        w_win_found = 1'b1;
      end
    end
  end

  // In GRANT, r_gnt_idx is the current owner and r_gnt is its one-hot mask.
  assign w_owner_req  = bus.req[r_gnt_idx];
  assign w_others_req = |(bus.req & ~r_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= 8'h00;
      r_gnt_idx    <= 3'd0;
      r_gnt_valid  <= 1'b0;
      r_preempt    <= 1'b0;
      r_hold       <= 8'd0;
      r_last_owner <= 3'd7;
    end else begin
      case (r_state)
        IDLE: begin
          r_preempt <= 1'b0;
          if (w_win_found) begin
            r_state      <= GRANT;
            r_gnt        <= 8'd1 << w_win_idx;
            r_gnt_idx    <= w_win_idx;
            r_gnt_valid  <= 1'b1;
            r_hold       <= 8'd0;
            r_last_owner <= w_win_idx;
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            // A release wins over a coincident timeout: no preempt pulse.
            r_state     <= IDLE;
            r_gnt       <= 8'h00;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
          end else if (r_hold == HOLD_LIMIT && w_others_req) begin
            r_state     <= IDLE;
            r_gnt       <= 8'h00;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b1;
          end else begin
            r_preempt <= 1'b0;
            if (r_hold != HOLD_LIMIT) begin
              r_hold <= r_hold + 8'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;
  localparam int MH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arbiter8_if ifc ();

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: owner is -1 when nobody holds the resource.
  int m_owner;
  int m_last;
  int m_idx;
  int m_cnt;
  bit m_pre;

  function automatic logic [7:0] m_gnt();
    logic [7:0] g;
    g = 8'h00;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 7;
    m_idx   = 0;
    m_cnt   = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    logic [7:0] others;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          if (r[(m_last + k) % 8]) begin
            m_owner = (m_last + k) % 8;
            break;
          end
        end
        m_last = m_owner;
        m_idx  = m_owner;
        m_cnt  = 0;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_cnt == MH - 1 && others != 8'h00) begin
        m_owner = -1;
        m_pre   = 1'b1;
      end else if (m_cnt < MH - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] g;
    g = m_gnt();
    chk({tag, ".gnt"}, 32'(ifc.gnt), 32'(g));
    chk({tag, ".valid"}, 32'(ifc.gnt_valid), 32'(m_owner >= 0));
    chk({tag, ".preempt"}, 32'(ifc.preempt), 32'(m_pre));
    chk({tag, ".idx"}, 32'(ifc.gnt_idx), 32'(m_idx));
    chk({tag, ".onehot0"}, 32'($onehot0(ifc.gnt)), 32'd1);
    chk({tag, ".valid_eq"}, 32'(ifc.gnt_valid), 32'(ifc.gnt != 8'h00));
    if (ifc.gnt_valid) chk({tag, ".decode"}, 32'(ifc.gnt), 32'(8'd1 << ifc.gnt_idx));
  endtask

  task automatic step(input logic [7:0] r, input string tag);
    ifc.req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset();
    ifc.req = 8'h00;
    rst = 1'b1;
    model_reset();
    #3;
    chk_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    checks = 0;
    errors = 0;
    ifc.req = 8'h00;
    rst = 1'b0;
    #1;
    do_reset();

    // Basic grant then hand-over with one idle cycle.
    step(8'h05, "b_first");
    chk("b_first_const", 32'(ifc.gnt), 32'h01);
    step(8'h04, "b_release");
    chk("b_gap_const", 32'(ifc.gnt), 32'h00);
    step(8'h04, "b_second");
    chk("b_second_const", 32'(ifc.gnt), 32'h04);
    chk("b_second_idx", 32'(ifc.gnt_idx), 32'd2);
    step(8'h00, "b_drop");

    // Full round with every requester active, each holding three cycles.
    do_reset();
    for (int n = 0; n < 9; n++) begin
      step(8'hFF, "rr_grant");
      chk("rr_order", 32'(ifc.gnt_idx), 32'(n % 8));
      step(8'hFF, "rr_hold1");
      step(8'hFF, "rr_hold2");
      r = 8'hFF;
      r[n % 8] = 1'b0;
      step(r, "rr_release");
      chk("rr_gap", 32'(ifc.gnt), 32'h00);
    end

    // Timeout preemption.
    do_reset();
    step(8'h08, "p_grant");
    step(8'h08, "p_h1");
    step(8'h0A, "p_h2");
    step(8'h0A, "p_h3");
    chk("p_still_owner", 32'(ifc.gnt), 32'h08);
    step(8'h0A, "p_fire");
    chk("p_pulse", 32'(ifc.preempt), 32'd1);
    chk("p_gnt_zero", 32'(ifc.gnt), 32'h00);
    step(8'h0A, "p_next");
    chk("p_next_owner", 32'(ifc.gnt), 32'h02);
    chk("p_pulse_gone", 32'(ifc.preempt), 32'd0);

    // Saturated counter with a lone requester never preempts.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      step(8'h20, "sat");
      chk("sat_gnt", 32'(ifc.gnt), 32'h20);
    end
    // Release coinciding with a pending other request is a plain release.
    step(8'h01, "sat_release");
    chk("sat_rel_nopre", 32'(ifc.preempt), 32'd0);

    // Asynchronous reset during a grant.
    do_reset();
    step(8'h40, "ar_grant");
    chk("ar_owner", 32'(ifc.gnt), 32'h40);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("ar_async");
    chk("ar_gnt_zero", 32'(ifc.gnt), 32'h00);
    #1;
    rst = 1'b0;
    step(8'h41, "ar_after");
    chk("ar_after_const", 32'(ifc.gnt), 32'h01);

    // Randomized traffic; the current owner usually keeps its request.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 5) == 0) r = 8'h00;
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      step(r, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, default 16; maximum grant-hold cycles before preemption when others are waiting; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: req  input  8  request vector; bit i = requester i wants the shared resource; held high while using it.
REQ-005 Port: gnt  output  8  one-hot grant; bit i = requester i owns the resource; all-zero = no owner.
REQ-006 Port: gnt_idx  output  3  binary index of the current or most recent owner; one-hot decode of gnt_idx equals gnt whenever gnt_valid = 1.
REQ-007 Port: gnt_valid  output  1  high exactly when gnt is nonzero.
REQ-008 Port: preempt  output  1  single-cycle pulse; an owner lost its grant through timeout.

Function
REQ-009 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner); all outputs SHALL be registered.
REQ-010 IDLE, req != 0 at an edge: at that edge, go to GRANT, set gnt, gnt_idx, gnt_valid for the winner, and clear the hold counter.
REQ-011 IDLE, req == 0: stay in IDLE; gnt = 0 and gnt_valid = 0; gnt_idx holds its last value.
REQ-012 Winner selection SHALL be round-robin: search from index (last_owner+1) mod 8 upward, wrapping 7->0; the first asserted req bit wins.
REQ-013 last_owner SHALL update only when a grant is issued; the last owner has lowest priority at the next arbitration.
REQ-014 Grant latency: req rising before edge N with the arbiter in IDLE SHALL give gnt valid after edge N (1 cycle).
REQ-015 GRANT, owner's req bit low at an edge: at that edge, go to IDLE, gnt = 0, gnt_valid = 0.
REQ-016 Every release SHALL be followed by at least one IDLE cycle; back-to-back grants to different owners are separated by exactly one cycle with gnt = 0.
REQ-017 Hold counter: 8 bits; counts edges spent in GRANT; saturates at MAX_HOLD-1.
REQ-018 Preemption fires when, at an edge, the counter equals MAX_HOLD-1, the owner's req is still high, and any other req bit is high.
REQ-019 On preemption: go to IDLE, gnt = 0, and pulse preempt high for exactly that one cycle; the next arbitration excludes nobody, but the round-robin order places the preempted owner last.
REQ-020 Counter at MAX_HOLD-1 with no other request pending: the owner keeps the grant indefinitely with no preempt; preemption fires at the first edge another request appears.
REQ-021 Owner's req low and preemption condition true at the same edge: treat as a normal release; preempt stays 0.
REQ-022 Requests from non-owners in GRANT SHALL be ignored until the arbiter returns to IDLE; there is no request latching.
REQ-023 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-024 While rst = 1: state = IDLE, gnt = 8'h00, gnt_valid = 0, gnt_idx = 3'd0, preempt = 0, hold counter = 0, last_owner = 3'd7 (first search starts at index 0). All of these take effect immediately, independent of clk.
REQ-025 Asserting rst during GRANT SHALL drop the grant asynchronously; after rst is released, the first arbitration follows REQ-024 values.

Verification
REQ-026 Reset, then req = 8'b0000_0101 held -> first gnt = 8'h01 after 1 edge; owner drops req bit 0 -> 1 idle cycle -> gnt = 8'h04, gnt_idx = 2.
REQ-027 req = 8'hFF, each owner releases after 3 cycles -> grant order 0,1,2,...,7,0; each grant followed by one gnt = 0 cycle; preempt never set.
REQ-028 MAX_HOLD = 4, req = 8'b0000_1000 held, req bit 1 rises 2 cycles after the grant -> gnt = 8'h08 for 4 cycles, then gnt = 0 with preempt = 1 for one cycle, then gnt = 8'h02.
REQ-029 MAX_HOLD = 4, only req bit 5 held for 20 cycles -> gnt = 8'h20 throughout, preempt = 0, counter saturated at 3.
REQ-030 Owner 6 granted, rst pulsed mid-cycle -> gnt = 0 before the next edge; after rst low with req = 8'b0100_0001 -> gnt = 8'h01.
REQ-031 All scenarios: checker asserts gnt one-hot or zero, gnt_valid == (gnt != 0), and gnt == decode(gnt_idx) whenever gnt_valid = 1.
